contador_pop_param: RTL and testbench

- Parametrised per-channel pop counter; successor of the fixed 5-channel, 5-bit contador.
- Sits beside the FIFO bank and counts one event per cycle that each FIFO's pop line is high.
- Counts can be read back one channel at a time via a req/idx handshake, but only once the system reports idle.
- Adds over the fixed version: configurable channel count and counter width, wrap or saturate mode, optional clear-on-read, sticky overflow flags, a synchronous clear, and an error pulse for out-of-range idx.

---
 rtl/contador_pkg.sv | 22 ++
 rtl/contador_cell.sv | 44 ++++
 rtl/contador_pop_param.sv | 114 +++++++++++
 tb/tb_contador_pop_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared state encoding and parameter checks for the pop counter
package contador_pkg;

  // Readout FSM: counting always runs; reads are only served in S_READ.
  typedef enum logic {
    S_COUNT = 1'b0,
    S_READ  = 1'b1
  } state_t;

  localparam int MAX_CH = 8;

  // True when an IDX_W-bit index can address every one of num_ch channels.
  function automatic bit idx_fits(input int num_ch, input int idx_w);
    return (64'd1 << idx_w) >= 64'(num_ch);
  endfunction

  // True when the channel count is inside the supported range.
  function automatic bit ch_count_ok(input int num_ch);
    return (num_ch >= 1) && (num_ch <= MAX_CH);
  endfunction

endpackage

// File: rtl/contador_cell.sv
// rtl/contador_cell.sv - one channel counter with wrap/saturate, read-clear and sticky overflow
module contador_cell
  import contador_pkg::*;
#(
  parameter int CNT_W    = 5,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             inc,
  input  logic             clr,
  input  logic             rd_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic at_max;

  assign at_max = (cnt == CNT_MAX);

  // Counter and overflow flag: clr beats read-clear, read-clear keeps a same-cycle pop, then plain counting.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (rd_clr) begin
      cnt <= inc ? CNT_ONE : '0;
    end else if (inc) begin
      if (at_max) begin
        ovf <= 1'b1;
        cnt <= SATURATE ? CNT_MAX : '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/contador_pop_param.sv
// rtl/contador_pop_param.sv - parametrised per-channel pop counter with idle-gated readout
module contador_pop_param
  import contador_pkg::*;
#(
  parameter int NUM_CH      = 5,
  parameter int CNT_W       = 5,
  parameter int IDX_W       = 3,
  parameter bit SATURATE    = 1'b0,
  parameter bit CLR_ON_READ = 1'b0
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [NUM_CH-1:0] pop,
  input  logic              idle,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  input  logic              clr,
  output logic [CNT_W-1:0]  data_out,
  output logic              valid,
  output logic              err,
  output logic [NUM_CH-1:0] ovf
);

  localparam bit PARAM_OK = idx_fits(NUM_CH, IDX_W) && ch_count_ok(NUM_CH);
  localparam logic [IDX_W:0] NUM_CH_X = (IDX_W + 1)'(NUM_CH);

  generate
    if (!PARAM_OK) begin : g_bad_param
      $error("contador_pop_param: NUM_CH must be 1..8 and fit in IDX_W bits");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic             idx_in_range;
  logic             rd_hit;
  logic             rd_miss;
  logic [CNT_W-1:0] rd_data;
  logic [CNT_W-1:0] cnt_arr [NUM_CH];
  logic [NUM_CH-1:0] rd_clr;

  assign idx_in_range = ({1'b0, idx} < NUM_CH_X);

  // State register; reset returns to counting-only mode.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= S_COUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state follows idle; reads and index errors are only decoded in S_READ.
  always_comb begin
    state_nxt = state;
    rd_hit    = 1'b0;
    rd_miss   = 1'b0;
    case (state)
      S_COUNT: begin
        if (idle) state_nxt = S_READ;
      end
      S_READ: begin
        if (!idle) state_nxt = S_COUNT;
        if (req) begin
          if (idx_in_range) rd_hit  = 1'b1;
          else              rd_miss = 1'b1;
        end
      end
      default: state_nxt = S_COUNT;
    endcase
  end

  // Read mux: selects the current (pre-update) count of the addressed channel.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == IDX_W'(i)) rd_data = cnt_arr[i];
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_cell
      assign rd_clr[g] = CLR_ON_READ && rd_hit && (idx == IDX_W'(g));

      contador_cell #(
        .CNT_W    (CNT_W),
        .SATURATE (SATURATE)
      ) u_cell (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (pop[g]),
        .clr     (clr),
        .rd_clr  (rd_clr[g]),
        .cnt     (cnt_arr[g]),
        .ovf     (ovf[g])
      );
    end
  endgenerate

  // Output registers: valid/err are single-cycle pulses, data_out only moves on a served read.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      valid <= rd_hit;
      err   <= rd_miss;
      if (rd_hit) data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_contador_pop_param.sv
// tb/tb_contador_pop_param.sv - self-checking bench for contador_pop_param (wrap, saturate, clear-on-read)
module tb_contador_pop_param;

  localparam int NV = 3;  // 0: wrap, 1: saturate, 2: wrap + clear-on-read
  localparam int NC = 5;
  localparam int MAXV = 31;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [4:0] pop = '0;
  logic       idle = 1'b0;
  logic       req = 1'b0;
  logic [2:0] idx = '0;
  logic       clr = 1'b0;

  logic [4:0] dout [NV];
  logic       vld  [NV];
  logic       erro [NV];
  logic [4:0] ovfo [NV];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  contador_pop_param #(.NUM_CH(5), .CNT_W(5), .IDX_W(3), .SATURATE(1'b0), .CLR_ON_READ(1'b0)) dut_wrap (
    .clk(clk), .reset_L(reset_L), .pop(pop), .idle(idle), .req(req), .idx(idx), .clr(clr),
    .data_out(dout[0]), .valid(vld[0]), .err(erro[0]), .ovf(ovfo[0]));

  contador_pop_param #(.NUM_CH(5), .CNT_W(5), .IDX_W(3), .SATURATE(1'b1), .CLR_ON_READ(1'b0)) dut_sat (
    .clk(clk), .reset_L(reset_L), .pop(pop), .idle(idle), .req(req), .idx(idx), .clr(clr),
    .data_out(dout[1]), .valid(vld[1]), .err(erro[1]), .ovf(ovfo[1]));

  contador_pop_param #(.NUM_CH(5), .CNT_W(5), .IDX_W(3), .SATURATE(1'b0), .CLR_ON_READ(1'b1)) dut_cor (
    .clk(clk), .reset_L(reset_L), .pop(pop), .idle(idle), .req(req), .idx(idx), .clr(clr),
    .data_out(dout[2]), .valid(vld[2]), .err(erro[2]), .ovf(ovfo[2]));

  // Behavioural model: plain integer counts, a read-enabled flag and the registered outputs.
  int   m_cnt  [NV][NC];
  bit   m_ovf  [NV][NC];
  bit   m_read [NV];
  bit   m_valid[NV];
  bit   m_err  [NV];
  int   m_data [NV];

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int v = 0; v < NV; v++) begin
        for (int c = 0; c < NC; c++) begin
          m_cnt[v][c] = 0;
          m_ovf[v][c] = 0;
        end
        m_read[v] = 0; m_valid[v] = 0; m_err[v] = 0; m_data[v] = 0;
      end
    end else begin
      for (int v = 0; v < NV; v++) begin
        int  ix;
        bit  hit;
        bit  miss;
        ix   = int'(idx);
        hit  = m_read[v] && req && (ix < NC);
        miss = m_read[v] && req && (ix >= NC);
        m_valid[v] = hit;
        m_err[v]   = miss;
        if (hit) m_data[v] = m_cnt[v][ix];
        for (int c = 0; c < NC; c++) begin
          if (clr) begin
            m_cnt[v][c] = 0;
            m_ovf[v][c] = 0;
          end else if (v == 2 && hit && ix == c) begin
            m_cnt[v][c] = pop[c] ? 1 : 0;
          end else if (pop[c]) begin
            if (m_cnt[v][c] + 1 > MAXV) begin
              m_ovf[v][c] = 1;
              m_cnt[v][c] = (v == 1) ? MAXV : 0;
            end else begin
              m_cnt[v][c] = m_cnt[v][c] + 1;
            end
          end
        end
        m_read[v] = idle;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_ovf(input int v);
    int r;
    r = 0;
    for (int c = 0; c < NC; c++) if (m_ovf[v][c]) r |= (1 << c);
    return r;
  endfunction

  // Every-cycle comparison of all three DUTs against the model, away from the active edge.
  always @(negedge clk) begin
    for (int v = 0; v < NV; v++) begin
      check($sformatf("cmp_valid_v%0d", v), int'(vld[v]), int'(m_valid[v]));
      check($sformatf("cmp_err_v%0d", v), int'(erro[v]), int'(m_err[v]));
      check($sformatf("cmp_data_v%0d", v), int'(dout[v]), m_data[v]);
      check($sformatf("cmp_ovf_v%0d", v), int'(ovfo[v]), model_ovf(v));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    check("reset_valid", int'(vld[0]), 0);
    check("reset_data", int'(dout[0]), 0);
    check("reset_ovf", int'(ovfo[0]), 0);
    reset_L = 1'b1;

    // Four single-cycle pops on ch0 in read mode, then read ch0.
    idle = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      pop = 5'b00001; tick();
      pop = 5'b00000; tick();
    end
    req = 1'b1; idx = 3'd0;
    tick();
    req = 1'b0;
    for (int v = 0; v < NV; v++) begin
      check($sformatf("t1_valid_v%0d", v), int'(vld[v]), 1);
      check($sformatf("t1_data_v%0d", v), int'(dout[v]), 4);
    end
    check("t1_model_data", m_data[0], 4);
    tick();
    check("t1_valid_drop", int'(vld[0]), 0);
    check("t1_data_hold", int'(dout[0]), 4);

    // Count while busy, then request in the very cycle idle rises.
    idle = 1'b0;
    tick();
    pop = 5'b00010;
    repeat (4) tick();
    pop = 5'b00000;
    idle = 1'b1; req = 1'b1; idx = 3'd1;
    tick();
    check("t2_no_valid_on_idle_rise", int'(vld[0]), 0);
    tick();
    req = 1'b0;
    check("t2_valid", int'(vld[0]), 1);
    check("t2_data", int'(dout[0]), 4);
    tick();

    // 33 pops on ch2: wrap gives 1, saturate gives 31, both flag overflow.
    pop = 5'b00100;
    repeat (33) tick();
    pop = 5'b00000;
    req = 1'b1; idx = 3'd2;
    tick();
    req = 1'b0;
    check("t3_wrap_data", int'(dout[0]), 1);
    check("t3_sat_data", int'(dout[1]), 31);
    check("t3_wrap_ovf2", int'(ovfo[0][2]), 1);
    check("t3_sat_ovf2", int'(ovfo[1][2]), 1);
    check("t3_model_sat", m_data[1], 31);
    tick();

    // Clear-on-read with a pop on the same channel in the read cycle.
    pop = 5'b01000;
    repeat (3) tick();
    req = 1'b1; idx = 3'd3;
    tick();
    pop = 5'b00000;
    check("t4_cor_data", int'(dout[2]), 3);
    check("t4_wrap_data", int'(dout[0]), 3);
    tick();
    req = 1'b0;
    check("t4_cor_reread", int'(dout[2]), 1);
    check("t4_wrap_reread", int'(dout[0]), 4);
    tick();

    // Out-of-range index.
    req = 1'b1; idx = 3'd5;
    tick();
    req = 1'b0;
    check("t5_err", int'(erro[0]), 1);
    check("t5_err_valid", int'(vld[0]), 0);
    check("t5_err_data_hold", int'(dout[0]), 4);
    tick();
    check("t5_err_drop", int'(erro[0]), 0);

    // clr with a read in the same cycle returns the pre-clear value.
    clr = 1'b1; req = 1'b1; idx = 3'd0;
    tick();
    clr = 1'b0;
    check("t5_clr_read_pre", int'(dout[0]), 4);
    tick();
    req = 1'b0;
    check("t5_clr_read_post", int'(dout[0]), 0);
    check("t5_clr_ovf_wrap", int'(ovfo[0]), 0);
    check("t5_clr_ovf_sat", int'(ovfo[1]), 0);
    tick();

    // Build up overflow and a pending valid, then drop reset between edges.
    pop = 5'b11111;
    repeat (33) tick();
    req = 1'b1; idx = 3'd4;
    tick();
    check("t6_pre_valid", int'(vld[0]), 1);
    check("t6_pre_data", int'(dout[0]), 1);
    check("t6_pre_ovf", int'(ovfo[0]), 31);
    #2;
    reset_L = 1'b0;
    #1;
    for (int v = 0; v < NV; v++) begin
      check($sformatf("t6_async_valid_v%0d", v), int'(vld[v]), 0);
      check($sformatf("t6_async_data_v%0d", v), int'(dout[v]), 0);
      check($sformatf("t6_async_ovf_v%0d", v), int'(ovfo[v]), 0);
    end
    pop = 5'b00000; req = 1'b0;
    tick();
    reset_L = 1'b1;
    tick();
    req = 1'b1;
    for (int c = 0; c < NC; c++) begin
      idx = 3'(c);
      tick();
      for (int v = 0; v < NV; v++) begin
        check($sformatf("t6_post_valid_v%0d_ch%0d", v, c), int'(vld[v]), 1);
        check($sformatf("t6_post_data_v%0d_ch%0d", v, c), int'(dout[v]), 0);
      end
    end
    req = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
